// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM state encoding and width constants.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam int unsigned APB_BYTE_W = 8;
    localparam int unsigned APB_WAIT_W = 4;

    // Number of byte-offset address bits below the register index.
    function automatic int unsigned apb_lane_lsb(input int unsigned data_w);
        return $clog2(data_w / APB_BYTE_W);
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: load, decrement while nonzero, registered zero flag.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [APB_WAIT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  zero_o
);

    logic [APB_WAIT_W-1:0] cnt_q, cnt_d;
    logic                  zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - APB_WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/apb_regbank_completer.sv
// APB completer fronting a bank of byte-strobed RW registers with read-only ID slots
// and a fixed number of wait states per access.
module apb_regbank_completer
    import apb_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 12,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          NUM_REGS    = 16,
    parameter int unsigned          WAIT_CYCLES = 2,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = NUM_REGS'(16'h8000),
    parameter logic [31:0]          ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic                   pselx,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [DATA_W-1:0]      pwdata,
    input  logic [DATA_W/8-1:0]    pstrb,
    output logic [DATA_W-1:0]      prdata,
    output logic                   pready,
    output logic                   pslverr
);

    localparam int unsigned LANES   = DATA_W / APB_BYTE_W;
    localparam int unsigned IDX_LSB = apb_lane_lsb(DATA_W);
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_t        state_q, state_d, phase_c;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [ADDR_W-1:0] idx_c;
    logic [IDX_W-1:0]  sel_c;
    logic              in_range_c, misaligned_c, ro_c, err_c, done_c, wait_zero;
    logic [DATA_W-1:0] rd_word_c;

    // Phase of the current bus cycle; state_q remembers the previous one so an
    // access phase is only honoured when it follows a setup phase.
    always_comb begin
        phase_c = ST_IDLE;
        if (pselx && !penable) begin
            phase_c = ST_SETUP;
        end else if (pselx && penable && (state_q != ST_IDLE)) begin
            phase_c = ST_ACCESS;
        end
        done_c  = (phase_c == ST_ACCESS) && wait_zero;
        state_d = done_c ? ST_IDLE : phase_c;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    apb_wait_counter u_wait (
        .clk        (pclk),
        .rst_n      (presetn),
        .load_i     (phase_c == ST_SETUP),
        .load_val_i (APB_WAIT_W'(WAIT_CYCLES)),
        .dec_i      (phase_c == ST_ACCESS),
        .zero_o     (wait_zero)
    );

    always_comb begin
        idx_c        = paddr >> IDX_LSB;
        misaligned_c = (paddr & ADDR_W'(LANES - 1)) != '0;
        in_range_c   = idx_c < ADDR_W'(NUM_REGS);
        sel_c        = IDX_W'(idx_c);
        ro_c         = in_range_c && RO_MASK[sel_c];
        err_c        = !in_range_c || misaligned_c || (pwrite && ro_c);
        rd_word_c    = ro_c ? DATA_W'(ID_VALUE) : regs_q[sel_c];
    end

    assign pready  = done_c;
    assign pslverr = done_c && err_c;
    assign prdata  = (done_c && !pwrite && !err_c) ? rd_word_c : '0;

    // Byte-lane commit happens only in the completion cycle of an error-free write.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (done_c && pwrite && !err_c) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (pstrb[b]) begin
                    regs_q[sel_c][b*APB_BYTE_W +: APB_BYTE_W] <= pwdata[b*APB_BYTE_W +: APB_BYTE_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regbank_completer.sv
// Directed + randomized bench for apb_regbank_completer: a default build (2 wait
// states) and a zero-wait build share one bus and are checked against register models.
module tb_apb_regbank_completer;

    localparam int unsigned WAIT_A = 2;
    localparam int unsigned WAIT_B = 0;
    localparam logic [31:0] ID     = 32'hA5B0_0001;

    logic        clk = 1'b0;
    logic        presetn;
    logic [11:0] paddr;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_done_cyc;

    logic [31:0] model_a [16];
    logic [31:0] model_b [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_regbank_completer #(.WAIT_CYCLES(WAIT_A)) dut_a (
        .pclk(clk), .presetn(presetn), .paddr(paddr), .pselx(psel_a), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_regbank_completer #(.WAIT_CYCLES(WAIT_B)) dut_b (
        .pclk(clk), .presetn(presetn), .paddr(paddr), .pselx(psel_b), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    // One APB transfer starting right after a clock edge; returns at the edge that ends it.
    task automatic xfer(input bit which, input logic [11:0] addr, input bit wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err, output int waits);
        bit got;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = st;
        penable = 1'b0;
        psel_a  = !which;
        psel_b  = which;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        got   = 1'b0;
        rd    = '0;
        err   = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (which ? pready_b : pready_a) begin
                got = 1'b1;
                rd  = which ? prdata_b : prdata_a;
                err = which ? pslverr_b : pslverr_a;
                last_done_cyc = cyc;
            end else begin
                check("wait_prdata", which ? prdata_b : prdata_a, 32'h0);
                check("wait_pslverr", 32'(which ? pslverr_b : pslverr_a), 32'h0);
                waits++;
            end
            @(posedge clk); #1;
        end
        check("pready_timeout", 32'(got), 32'h1);
    endtask

    // Runs a transfer and compares it with the register-bank model.
    task automatic do_xfer(input bit which, input logic [11:0] addr, input bit wr,
                           input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd_o);
        int          idx;
        bit          e;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic        err;
        int          waits;
        idx = int'(addr >> 2);
        e = (addr[1:0] != 2'b00) || (idx >= 16) || (wr && idx == 15);
        exp_rd = 32'h0;
        if (!e) begin
            if (idx == 15) exp_rd = ID;
            else if (which) exp_rd = model_b[idx];
            else exp_rd = model_a[idx];
        end
        xfer(which, addr, wr, wd, st, rd, err, waits);
        check("wait_states", 32'(waits), 32'(which ? WAIT_B : WAIT_A));
        check("pslverr", 32'(err), 32'(e));
        if (!wr) check("prdata", rd, exp_rd);
        if (wr && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) begin
                    if (which) model_b[idx][b*8 +: 8] = wd[b*8 +: 8];
                    else       model_a[idx][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
        end
        rd_o = rd;
    endtask

    initial begin
        logic [31:0] rd;
        logic [11:0] a;
        bit          wr;
        int          t0;

        for (int i = 0; i < 16; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end

        // Reset with a busy-looking bus: everything must stay quiet.
        presetn = 1'b0;
        paddr = 12'h004; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        psel_a = 1'b1; psel_b = 1'b1; penable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready_a", 32'(pready_a), 32'h0);
        check("rst_pslverr_a", 32'(pslverr_a), 32'h0);
        check("rst_prdata_a", prdata_a, 32'h0);
        check("rst_pready_b", 32'(pready_b), 32'h0);
        check("rst_prdata_b", prdata_b, 32'h0);
        bus_idle();
        presetn = 1'b1;
        @(posedge clk); #1;

        // Basic write/read with wait states.
        do_xfer(0, 12'h004, 1, 32'hDEAD_BEEF, 4'hF, rd);
        do_xfer(0, 12'h004, 0, 32'h0, 4'h0, rd);
        check("deadbeef", rd, 32'hDEAD_BEEF);

        // Partial strobes.
        do_xfer(0, 12'h008, 1, 32'h1122_3344, 4'b0101, rd);
        do_xfer(0, 12'h008, 0, 32'h0, 4'h0, rd);
        check("strobe_merge", rd, 32'h0022_0044);

        // Read-only ID register.
        do_xfer(0, 12'h03C, 0, 32'h0, 4'h0, rd);
        check("id_read", rd, ID);
        do_xfer(0, 12'h03C, 1, 32'h0, 4'hF, rd);
        do_xfer(0, 12'h03C, 0, 32'h0, 4'h0, rd);
        check("id_reread", rd, ID);

        // Out-of-range and misaligned.
        do_xfer(0, 12'h040, 0, 32'h0, 4'h0, rd);
        do_xfer(0, 12'h005, 0, 32'h0, 4'h0, rd);

        // Zero strobes: no commit, no error.
        do_xfer(0, 12'h010, 1, 32'h5555_AAAA, 4'h0, rd);
        do_xfer(0, 12'h010, 0, 32'h0, 4'h0, rd);
        bus_idle();

        // Abort during access: pselx drops before completion.
        paddr = 12'h010; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        psel_a = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_a = 1'b0;
        @(negedge clk);
        check("abort_pready", 32'(pready_a), 32'h0);
        bus_idle();
        do_xfer(0, 12'h010, 0, 32'h0, 4'h0, rd);
        bus_idle();

        // penable without a setup phase is ignored.
        paddr = 12'h000; pwrite = 1'b1; pwdata = 32'h1234_5678; pstrb = 4'hF;
        psel_a = 1'b1; penable = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("idle_penable", 32'(pready_a), 32'h0);
            @(posedge clk); #1;
        end
        bus_idle();
        do_xfer(0, 12'h000, 0, 32'h0, 4'h0, rd);
        bus_idle();

        // Zero-wait build: back-to-back writes, no idle cycle between.
        t0 = cyc;
        do_xfer(1, 12'h000, 1, 32'h0BAD_F00D, 4'hF, rd);
        do_xfer(1, 12'h004, 1, 32'h7777_1111, 4'hF, rd);
        check("b2b_cycles", 32'(last_done_cyc - t0), 32'd3);
        do_xfer(1, 12'h000, 0, 32'h0, 4'h0, rd);
        do_xfer(1, 12'h004, 0, 32'h0, 4'h0, rd);
        bus_idle();

        // Randomized traffic on both builds.
        for (int i = 0; i < 60; i++) begin
            a = 12'($urandom_range(0, 17) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 12'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            do_xfer(i % 4 == 3, a, wr, $urandom, 4'($urandom), rd);
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();

        // Reset in the middle of a write access.
        paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        psel_a = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("midrst_pre_pready", 32'(pready_a), 32'h0);
        presetn = 1'b0;
        #1;
        check("midrst_pready", 32'(pready_a), 32'h0);
        check("midrst_pslverr", 32'(pslverr_a), 32'h0);
        check("midrst_prdata", prdata_a, 32'h0);
        @(posedge clk); #1;
        check("midrst_pready_held", 32'(pready_a), 32'h0);
        bus_idle();
        presetn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        do_xfer(0, 12'h00C, 0, 32'h0, 4'h0, rd);
        check("midrst_reg", rd, 32'h0);
        do_xfer(0, 12'h004, 0, 32'h0, 4'h0, rd);
        do_xfer(1, 12'h000, 0, 32'h0, 4'h0, rd);
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_regbank_completer.md
APB_REGBANK_COMPLETER -- requirements
Module: apb_regbank_completer

Interface
REQ-001 Parameter ADDR_W, default 12, APB address width in bits.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 8, 16 or 32.
REQ-003 Parameter NUM_REGS, default 16, number of DATA_W-wide registers; 1..2**(ADDR_W-2).
REQ-004 Parameter WAIT_CYCLES, default 2, wait states inserted per access; 0..15.
REQ-005 Parameter RO_MASK, default 16'h8000, bit i set = register i is read-only.
REQ-006 Parameter ID_VALUE, default 32'hA5B0_0001, constant returned by read-only registers (truncated to DATA_W).
REQ-007 pclk  in  1  clock; all state updates on rising edge.
REQ-008 presetn  in  1  reset; one clock, asynchronous assert, active-low.
REQ-009 paddr  in  ADDR_W  byte address.
REQ-010 pselx  in  1  completer select.
REQ-011 penable  in  1  access phase indicator.
REQ-012 pwrite  in  1  1 = write, 0 = read.
REQ-013 pwdata  in  DATA_W  write data.
REQ-014 pstrb  in  DATA_W/8  byte write strobes.
REQ-015 prdata  out  DATA_W  read data.
REQ-016 pready  out  1  transfer complete.
REQ-017 pslverr  out  1  transfer error.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; IDLE->SETUP when pselx=1 and penable=0.
REQ-019 SETUP->ACCESS unconditionally next cycle; wait counter loaded with WAIT_CYCLES on this transition.
REQ-020 In ACCESS, counter decrements each cycle while nonzero; pready=1 combinationally iff state=ACCESS, penable=1, pselx=1, counter=0.
REQ-021 WAIT_CYCLES=0: pready=1 in first ACCESS cycle (zero-wait transfer, 2 cycles total).
REQ-022 On completion cycle: next state SETUP if pselx=1 and penable=0 is seen the following cycle; otherwise IDLE; back-to-back transfers add no idle cycle.
REQ-023 pselx=0 while in SETUP or ACCESS: abort to IDLE, no register update, pready=0.
REQ-024 penable=1 while in IDLE: ignored, no state change.
REQ-025 Register index = paddr[ADDR_W-1:2] (DATA_W=32); index width scales with DATA_W/8.
REQ-026 Error condition: index >= NUM_REGS, or low address bits nonzero (misaligned), or write to RO register.
REQ-027 pslverr=1 only in the completion cycle of an erroring transfer; 0 at all other times.
REQ-028 Write commits on completion cycle only, only if no error, only bytes with pstrb bit set; pstrb=0 commits nothing, no error.
REQ-029 Read: prdata = register (or ID_VALUE for RO) in completion cycle; 0 on error and in all non-completion cycles.
REQ-030 Address, data, strobes, direction sampled from bus in completion cycle; bus held stable by requester per APB.

Reset
REQ-031 presetn=0: state IDLE, counter 0, all RW registers 0, prdata 0, pready 0, pslverr 0, asynchronously.
REQ-032 Reset mid-transfer aborts with no register update; first transfer after release starts from IDLE.

Structure
REQ-033 Shared package apb_pkg holds FSM state enum (apb_state_t) and APB width constants.
REQ-034 One sub-module apb_wait_counter (load, decrement, zero flag); register array and decode stay in top.

Verification
REQ-035 Default params: write 32'hDEAD_BEEF to 0x004, pstrb=4'hF, then read 0x004 -> prdata 32'hDEAD_BEEF, pready after exactly 2 wait cycles, pslverr=0.
REQ-036 Write 32'h1122_3344 pstrb=4'b0101 to 0x008 (was 0) -> read returns 32'h0022_0044.
REQ-037 Read 0x03C -> 32'hA5B0_0001; write 32'h0 to 0x03C -> pslverr=1, reread still 32'hA5B0_0001.
REQ-038 Read 0x040 (index 16) and 0x005 (misaligned) -> pslverr=1, prdata=0 each.
REQ-039 WAIT_CYCLES=0 build: back-to-back writes to 0x000 and 0x004 -> each pready in first ACCESS cycle, no idle between.
REQ-040 Assert presetn=0 during ACCESS of write 32'hFFFF_FFFF to 0x00C -> register reads 0 after reset, outputs 0 during reset.
